mem_access_stage: RTL and testbench



---
 rtl/mem_stage_pkg.sv | 25 ++
 rtl/mem_lane_counter.sv | 33 +++
 rtl/mem_access_stage.sv | 209 ++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types for the memory access stage: operation codes and sequencer states.
// No logic of its own, so no latency.
// No handshake of its own, so no backpressure.
package mem_stage_pkg;

    localparam int DEF_REGI_CONT = 4;
    localparam int DEF_VECT_CONT = 2;

    // Codes 5..7 are not listed and decode as pass-through.
    typedef enum logic [2:0] {
        OP_PASS = 3'd0,
        OP_SLD  = 3'd1,
        OP_SST  = 3'd2,
        OP_VLD  = 3'd3,
        OP_VST  = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/mem_lane_counter.sv
// Lane index for a memory sequence, with a flag on the final lane.
// The index updates 1 cycle after load/step; the last flag is combinational on the index.
// No handshake: the owner decides when to load and step.
module mem_lane_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] len_m1,
    input  logic         step,
    output logic [W-1:0] lane,
    output logic         last
);

    logic [W-1:0] len_q;

    // Restart at lane 0 with a new length on load, otherwise advance on step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane  <= '0;
            len_q <= '0;
        end else if (load) begin
            lane  <= '0;
            len_q <= len_m1;
        end else if (step) begin
            lane  <= lane + W'(1);
        end
    end

    assign last = (lane == len_q);

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: pass-through results retire directly; loads/stores are sequenced one word per cycle.
// PASS retires 1 cycle after accept, stores N+1 cycles, loads N+2 cycles (N = 1 scalar, VECT_SIZE vector).
// ready_o is low for the whole duration of a load/store sequence; PASS keeps full throughput.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter  int REGI_CONT = DEF_REGI_CONT,
    parameter  int VECT_CONT = DEF_VECT_CONT,
    localparam int REGI_SIZE = 2**REGI_CONT,
    localparam int VECT_SIZE = 2**VECT_CONT
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           valid_i,
    output logic                           ready_o,
    input  logic [2:0]                     op_i,
    input  logic [REGI_CONT-1:0]           dest_i,
    input  logic [REGI_SIZE-1:0]           addr_i,
    input  logic [REGI_SIZE-1:0]           alu_i,
    input  logic [VECT_SIZE*REGI_SIZE-1:0] wdata_i,
    output logic                           mem_we_o,
    output logic [REGI_SIZE-1:0]           mem_a_o,
    output logic [REGI_SIZE-1:0]           mem_wd_o,
    input  logic [REGI_SIZE-1:0]           mem_rd_i,
    output logic                           wb_valid_o,
    output logic                           wb_reg_we_o,
    output logic                           wb_vec_o,
    output logic [REGI_CONT-1:0]           wb_dest_o,
    output logic [VECT_SIZE*REGI_SIZE-1:0] wb_data_o
);

    localparam int WD = VECT_SIZE * REGI_SIZE;

    state_e               state_q, state_d;
    op_e                  op_in, op_q;
    logic                 is_ld_in, is_st_in, is_vec_in;
    logic                 accept;
    logic                 cnt_load, cnt_step;
    logic [VECT_CONT-1:0] len_m1_in;
    logic [VECT_CONT-1:0] lane, nxt_lane;
    logic                 last;
    logic [REGI_SIZE-1:0] nxt_addr;
    logic [REGI_CONT-1:0] dest_q;
    logic [REGI_SIZE-1:0] base_q;
    logic [REGI_SIZE-1:0] wlane_q [VECT_SIZE];
    logic [REGI_SIZE-1:0] rbuf_q  [VECT_SIZE];
    logic                 cap_vld_q;
    logic [VECT_CONT-1:0] cap_idx_q;
    logic [WD-1:0]        rd_merged;

    assign op_in     = op_e'(op_i);
    assign is_ld_in  = (op_in == OP_SLD) || (op_in == OP_VLD);
    assign is_st_in  = (op_in == OP_SST) || (op_in == OP_VST);
    assign is_vec_in = (op_in == OP_VLD) || (op_in == OP_VST);
    assign len_m1_in = is_vec_in ? '1 : '0;

    assign ready_o = (state_q == ST_IDLE) && !rst_i;
    assign accept  = valid_i && ready_o;

    // Address and lane of the word after the current one; wraps modulo the address width.
    assign nxt_lane = lane + VECT_CONT'(1);
    assign nxt_addr = base_q + REGI_SIZE'(nxt_lane);

    mem_lane_counter #(
        .W(VECT_CONT)
    ) u_lane_cnt (
        .clk    (clk_i),
        .rst    (rst_i),
        .load   (cnt_load),
        .len_m1 (len_m1_in),
        .step   (cnt_step),
        .lane   (lane),
        .last   (last)
    );

    // Captured load lanes, with the word arriving this cycle folded in so DRAIN can retire directly.
    always_comb begin
        rd_merged = '0;
        for (int k = 0; k < VECT_SIZE; k++) begin
            rd_merged[k*REGI_SIZE +: REGI_SIZE] =
                (cap_vld_q && (cap_idx_q == VECT_CONT'(k))) ? mem_rd_i : rbuf_q[k];
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and lane counter control.
    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cnt_load = 1'b1;
                    if (is_st_in) begin
                        state_d = ST_WRITE;
                    end else if (is_ld_in) begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_WRITE: begin
                if (last) state_d = ST_IDLE;
                else      cnt_step = 1'b1;
            end
            ST_READ: begin
                if (last) state_d = ST_DRAIN;
                else      cnt_step = 1'b1;
            end
            ST_DRAIN: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request latch, memory port, read capture and retire outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q        <= OP_PASS;
            dest_q      <= '0;
            base_q      <= '0;
            cap_vld_q   <= 1'b0;
            cap_idx_q   <= '0;
            mem_we_o    <= 1'b0;
            mem_a_o     <= '0;
            mem_wd_o    <= '0;
            wb_valid_o  <= 1'b0;
            wb_reg_we_o <= 1'b0;
            wb_vec_o    <= 1'b0;
            wb_dest_o   <= '0;
            wb_data_o   <= '0;
            for (int k = 0; k < VECT_SIZE; k++) begin
                wlane_q[k] <= '0;
                rbuf_q[k]  <= '0;
            end
        end else begin
            wb_valid_o <= 1'b0;
            mem_we_o   <= 1'b0;
            cap_vld_q  <= 1'b0;
            if (cap_vld_q) begin
                rbuf_q[cap_idx_q] <= mem_rd_i;
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q   <= op_in;
                        dest_q <= dest_i;
                        base_q <= addr_i;
                        for (int k = 0; k < VECT_SIZE; k++) begin
                            wlane_q[k] <= wdata_i[k*REGI_SIZE +: REGI_SIZE];
                            rbuf_q[k]  <= '0;
                        end
                        if (is_st_in) begin
                            mem_we_o <= 1'b1;
                            mem_a_o  <= addr_i;
                            mem_wd_o <= wdata_i[REGI_SIZE-1:0];
                        end else if (is_ld_in) begin
                            mem_a_o  <= addr_i;
                        end else begin
                            wb_valid_o  <= 1'b1;
                            wb_reg_we_o <= 1'b1;
                            wb_vec_o    <= 1'b0;
                            wb_dest_o   <= dest_i;
                            wb_data_o   <= WD'(alu_i);
                        end
                    end
                end
                ST_WRITE: begin
                    if (!last) begin
                        mem_we_o <= 1'b1;
                        mem_a_o  <= nxt_addr;
                        mem_wd_o <= wlane_q[nxt_lane];
                    end else begin
                        wb_valid_o  <= 1'b1;
                        wb_reg_we_o <= 1'b0;
                        wb_vec_o    <= (op_q == OP_VST);
                        wb_dest_o   <= dest_q;
                    end
                end
                ST_READ: begin
                    // The word addressed now returns next cycle; remember which lane it is.
                    cap_vld_q <= 1'b1;
                    cap_idx_q <= lane;
                    if (!last) begin
                        mem_a_o <= nxt_addr;
                    end
                end
                ST_DRAIN: begin
                    wb_valid_o  <= 1'b1;
                    wb_reg_we_o <= 1'b1;
                    wb_vec_o    <= (op_q == OP_VLD);
                    wb_dest_o   <= dest_q;
                    wb_data_o   <= rd_merged;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a 1-cycle-latency synchronous memory model.
// Inputs are driven and outputs sampled on the falling clock edge.
// Memory reads return addr^0xA5A5, except address 0x0020 which holds 0x00C3.
module tb_mem_access_stage;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [2:0]  op_i = 3'd0;
    logic [3:0]  dest_i = 4'd0;
    logic [15:0] addr_i = 16'h0;
    logic [15:0] alu_i = 16'h0;
    logic [63:0] wdata_i = 64'h0;
    logic        mem_we_o;
    logic [15:0] mem_a_o;
    logic [15:0] mem_wd_o;
    logic [15:0] mem_rd_i = 16'h0;
    logic        wb_valid_o;
    logic        wb_reg_we_o;
    logic        wb_vec_o;
    logic [3:0]  wb_dest_o;
    logic [63:0] wb_data_o;

    int n_checks = 0;
    int n_errors = 0;
    int n_accepts = 0;

    mem_access_stage dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .op_i        (op_i),
        .dest_i      (dest_i),
        .addr_i      (addr_i),
        .alu_i       (alu_i),
        .wdata_i     (wdata_i),
        .mem_we_o    (mem_we_o),
        .mem_a_o     (mem_a_o),
        .mem_wd_o    (mem_wd_o),
        .mem_rd_i    (mem_rd_i),
        .wb_valid_o  (wb_valid_o),
        .wb_reg_we_o (wb_reg_we_o),
        .wb_vec_o    (wb_vec_o),
        .wb_dest_o   (wb_dest_o),
        .wb_data_o   (wb_data_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        mem_rd_i <= (mem_a_o == 16'h0020) ? 16'h00C3 : (mem_a_o ^ 16'hA5A5);
        if (valid_i && ready_o) n_accepts++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic drive(input logic [2:0] op, input logic [3:0] dest,
                         input logic [15:0] addr, input logic [15:0] alu, input logic [63:0] wd);
        valid_i = 1'b1;
        op_i    = op;
        dest_i  = dest;
        addr_i  = addr;
        alu_i   = alu;
        wdata_i = wd;
    endtask

    logic [15:0] vld_addr [4];
    logic [15:0] vst_data [4];
    int acc_before;

    initial begin
        vld_addr[0] = 16'hFFFE; vld_addr[1] = 16'hFFFF; vld_addr[2] = 16'h0000; vld_addr[3] = 16'h0001;
        vst_data[0] = 16'h1111; vst_data[1] = 16'h2222; vst_data[2] = 16'h3333; vst_data[3] = 16'h4444;

        // Reset state
        @(negedge clk_i);
        check("rst_ready", ready_o, 0);
        check("rst_wb_valid", wb_valid_o, 0);
        check("rst_mem_we", mem_we_o, 0);
        check("rst_mem_a", mem_a_o, 0);
        check("rst_wb_data", wb_data_o, 0);
        rst_i = 1'b0;
        #1;
        check("post_rst_ready", ready_o, 1);

        // Two back-to-back PASS ops
        @(negedge clk_i);
        drive(3'd0, 4'd3, 16'h0, 16'hBEEF, 64'h0);
        check("pass0_ready", ready_o, 1);
        step();
        check("pass0_valid", wb_valid_o, 1);
        check("pass0_data", wb_data_o, 64'h0000_0000_0000_BEEF);
        check("pass0_dest", wb_dest_o, 3);
        check("pass0_regwe", wb_reg_we_o, 1);
        check("pass0_vec", wb_vec_o, 0);
        check("pass1_ready", ready_o, 1);
        drive(3'd0, 4'd3, 16'h0, 16'h1234, 64'h0);
        step();
        check("pass1_valid", wb_valid_o, 1);
        check("pass1_data", wb_data_o, 64'h0000_0000_0000_1234);
        check("pass1_ready_after", ready_o, 1);
        // Undefined code 7 behaves as PASS
        drive(3'd7, 4'd6, 16'h0, 16'h0BAD, 64'h0);
        step();
        valid_i = 1'b0;
        check("op7_valid", wb_valid_o, 1);
        check("op7_data", wb_data_o, 64'h0000_0000_0000_0BAD);
        check("op7_dest", wb_dest_o, 6);
        step();
        check("idle_valid", wb_valid_o, 0);
        check("idle_hold_data", wb_data_o, 64'h0000_0000_0000_0BAD);

        // Vector store at 0x0010
        drive(3'd4, 4'd5, 16'h0010, 16'h0, 64'h4444_3333_2222_1111);
        step();
        valid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("vst_we%0d", k), mem_we_o, 1);
            check($sformatf("vst_a%0d", k), mem_a_o, 16'h0010 + 16'(k));
            check($sformatf("vst_wd%0d", k), mem_wd_o, vst_data[k]);
            check($sformatf("vst_ready%0d", k), ready_o, 0);
            check($sformatf("vst_wbv%0d", k), wb_valid_o, 0);
            step();
        end
        check("vst_ret_valid", wb_valid_o, 1);
        check("vst_ret_regwe", wb_reg_we_o, 0);
        check("vst_ret_we", mem_we_o, 0);
        check("vst_ret_ready", ready_o, 1);

        // Vector load wrapping across 0xFFFF
        drive(3'd3, 4'd7, 16'hFFFE, 16'h0, 64'h0);
        step();
        valid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("vld_a%0d", k), mem_a_o, vld_addr[k]);
            check($sformatf("vld_we%0d", k), mem_we_o, 0);
            check($sformatf("vld_ready%0d", k), ready_o, 0);
            step();
        end
        check("vld_drain_ready", ready_o, 0);
        check("vld_drain_wbv", wb_valid_o, 0);
        step();
        check("vld_valid", wb_valid_o, 1);
        check("vld_data", wb_data_o, 64'hA5A4_A5A5_5A5A_5A5B);
        check("vld_vec", wb_vec_o, 1);
        check("vld_regwe", wb_reg_we_o, 1);
        check("vld_dest", wb_dest_o, 7);

        // Scalar load; upper lanes must be cleared after the vector load
        drive(3'd1, 4'd2, 16'h0020, 16'h0, 64'h0);
        step();
        valid_i = 1'b0;
        check("sld_a", mem_a_o, 16'h0020);
        check("sld_ready", ready_o, 0);
        step();
        check("sld_drain_wbv", wb_valid_o, 0);
        step();
        check("sld_valid", wb_valid_o, 1);
        check("sld_data", wb_data_o, 64'h0000_0000_0000_00C3);
        check("sld_vec", wb_vec_o, 0);
        check("sld_dest", wb_dest_o, 2);

        // Reset in cycle 3 of a vector load drops it
        drive(3'd3, 4'd9, 16'h0040, 16'h0, 64'h0);
        step();
        valid_i = 1'b0;
        step();
        step();
        rst_i = 1'b1;
        #1;
        check("rst_mid_ready", ready_o, 0);
        check("rst_mid_mem_a", mem_a_o, 0);
        check("rst_mid_wb_data", wb_data_o, 0);
        check("rst_mid_wb_dest", wb_dest_o, 0);
        check("rst_mid_wb_valid", wb_valid_o, 0);
        step();
        check("rst_held_ready", ready_o, 0);
        rst_i = 1'b0;
        #1;
        check("rst_rel_ready", ready_o, 1);
        for (int c = 0; c < 8; c++) begin
            step();
            check($sformatf("rst_no_retire%0d", c), wb_valid_o, 0);
        end

        // valid_i held: VST then SLD, SLD accepted once at cycle 5
        acc_before = n_accepts;
        drive(3'd4, 4'd1, 16'h0030, 16'h0, 64'h4444_3333_2222_1111);
        step();
        drive(3'd1, 4'd4, 16'h0020, 16'h0, 64'h0);
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("hold_ready%0d", c), ready_o, 0);
            check($sformatf("hold_we%0d", c), mem_we_o, 1);
            step();
        end
        check("hold_c5_ready", ready_o, 1);
        check("hold_c5_vst_ret", wb_valid_o, 1);
        step();
        valid_i = 1'b0;
        check("hold_c6_a", mem_a_o, 16'h0020);
        check("hold_c6_we", mem_we_o, 0);
        check("hold_c6_ready", ready_o, 0);
        step();
        check("hold_c7_wbv", wb_valid_o, 0);
        step();
        check("hold_c8_valid", wb_valid_o, 1);
        check("hold_c8_data", wb_data_o, 64'h0000_0000_0000_00C3);
        check("hold_c8_dest", wb_dest_o, 4);
        step();
        check("hold_c9_wbv", wb_valid_o, 0);
        check("hold_accepts", n_accepts - acc_before, 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
